// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through / no-write-allocate data cache
// controller for a pipelined core's MEM stage. Each of the 2^idx_bits lines
// holds one word plus a tag and a valid bit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   datamem_add         word address from MEM stage
//   datamem_writedata   store data from MEM stage
//   modified_mem_we     store request (wins over mem_re when both set)
//   mem_re              load request
//   datamem_readdata    load data (hit data, fill data in DONE, else 0)
//   stall_cmis          pipeline enable: 1 = run, 0 = freeze
//   mm_req/mm_we        main-memory request / write strobe
//   mm_addr/mm_wdata    main-memory address / write data
//   mm_rdata/mm_ack     main-memory read data / one-cycle completion strobe
module dcache_ctrl #(
  parameter int numbits  = 16,
  parameter int idx_bits = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [numbits-1:0] datamem_add,
  input  logic [numbits-1:0] datamem_writedata,
  input  logic               modified_mem_we,
  input  logic               mem_re,
  output logic [numbits-1:0] datamem_readdata,
  output logic               stall_cmis,
  output logic               mm_req,
  output logic               mm_we,
  output logic [numbits-1:0] mm_addr,
  output logic [numbits-1:0] mm_wdata,
  input  logic [numbits-1:0] mm_rdata,
  input  logic               mm_ack
);

  localparam int LINES = 1 << idx_bits;
  localparam int TAGW  = numbits - idx_bits;

  typedef enum logic [1:0] {IDLE, RMISS, WTHRU, DONE} state_t;

  state_t             state_q, state_d;
  logic [numbits-1:0] addr_q, addr_d;
  logic [numbits-1:0] wdata_q, wdata_d;
  logic [numbits-1:0] fill_q, fill_d;
  logic               rd_done_q, rd_done_d;   // DONE follows a read (vs. a write)

  logic [LINES-1:0]   valid_q;
  logic [TAGW-1:0]    tag_q  [LINES];
  logic [numbits-1:0] data_q [LINES];

  logic [idx_bits-1:0] req_idx, lat_idx;
  logic [TAGW-1:0]     req_tag, lat_tag;
  logic                access, hit, lat_hit, line_fill, line_upd;

  assign req_idx = datamem_add[idx_bits-1:0];
  assign req_tag = datamem_add[numbits-1:idx_bits];
  assign lat_idx = addr_q[idx_bits-1:0];
  assign lat_tag = addr_q[numbits-1:idx_bits];

  // Reset masks requests so outputs sit at their idle values while rst is held.
  assign access  = ~rst & (mem_re | modified_mem_we);
  assign hit     = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] & (tag_q[lat_idx] == lat_tag);

  // Line writes are suppressed on a reset edge so an abandoned miss leaves no trace.
  assign line_fill = ~rst & (state_q == RMISS) & mm_ack;
  assign line_upd  = ~rst & (state_q == WTHRU) & mm_ack & lat_hit;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    fill_d           = fill_q;
    rd_done_d        = rd_done_q;
    stall_cmis       = 1'b1;
    datamem_readdata = '0;
    mm_req           = 1'b0;
    mm_we            = 1'b0;
    mm_addr          = '0;
    mm_wdata         = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (modified_mem_we) begin
            stall_cmis = 1'b0;
            addr_d     = datamem_add;
            wdata_d    = datamem_writedata;
            state_d    = WTHRU;
          end else if (hit) begin
            datamem_readdata = data_q[req_idx];
          end else begin
            stall_cmis = 1'b0;
            addr_d     = datamem_add;
            state_d    = RMISS;
          end
        end
      end
      RMISS: begin
        stall_cmis = 1'b0;
        mm_req     = 1'b1;
        mm_addr    = addr_q;
        if (mm_ack) begin
          fill_d    = mm_rdata;
          rd_done_d = 1'b1;
          state_d   = DONE;
        end
      end
      WTHRU: begin
        stall_cmis = 1'b0;
        mm_req     = 1'b1;
        mm_we      = 1'b1;
        mm_addr    = addr_q;
        mm_wdata   = wdata_q;
        if (mm_ack) begin
          rd_done_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        datamem_readdata = rd_done_q ? fill_q : '0;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      rd_done_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      fill_q    <= fill_d;
      rd_done_q <= rd_done_d;
      if (line_fill) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Tag and data storage is not reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_q[lat_idx]  <= lat_tag;
      data_q[lat_idx] <= mm_rdata;
    end else if (line_upd) begin
      data_q[lat_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected main-memory
// requests and expected access completions; a negedge monitor pops and
// compares them as the DUT presents them.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] datamem_add = '0;
  logic [15:0] datamem_writedata = '0;
  logic        modified_mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [15:0] datamem_readdata;
  logic        stall_cmis;
  logic        mm_req;
  logic        mm_we;
  logic [15:0] mm_addr;
  logic [15:0] mm_wdata;
  logic [15:0] mm_rdata = '0;
  logic        mm_ack = 1'b0;

  dcache_ctrl #(.numbits(16), .idx_bits(4)) dut (
    .clk(clk), .rst(rst),
    .datamem_add(datamem_add), .datamem_writedata(datamem_writedata),
    .modified_mem_we(modified_mem_we), .mem_re(mem_re),
    .datamem_readdata(datamem_readdata), .stall_cmis(stall_cmis),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_ack(mm_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] data;
    int          stalls;
  } comp_t;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mmx_t;

  comp_t compq[$];
  mmx_t  mmq[$];
  int    checks = 0;
  int    passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Main-memory responder: ack in the lat-th cycle of a request.
  int          lat = 1;
  logic [15:0] resp = '0;
  int          mcnt = 0;
  int          stray_seq = 0;
  int          stray_done = 0;
  always @(negedge clk) begin
    mm_ack = 1'b0;
    if (stray_seq != stray_done) begin
      mm_ack     = 1'b1;
      mm_rdata   = 16'hDEAD;
      stray_done = stray_seq;
    end else if (mm_req) begin
      mcnt++;
      if (mcnt == lat) begin
        mm_ack   = 1'b1;
        mm_rdata = resp;
        mcnt     = 0;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Monitor
  logic prev_req = 1'b0;
  int   scnt = 0;
  always @(negedge clk) begin
    mmx_t  m;
    comp_t c;
    if (mm_req && !prev_req) begin
      if (mmq.size() == 0) check("unexpected_mm_req", 32'(mm_addr), 32'hFFFF_FFFF);
      else begin
        m = mmq.pop_front();
        check("mm_we", 32'(mm_we), 32'(m.we));
        check("mm_addr", 32'(mm_addr), 32'(m.addr));
        if (m.we) check("mm_wdata", 32'(mm_wdata), 32'(m.wdata));
      end
    end
    prev_req = mm_req;
    if (!rst && (mem_re || modified_mem_we)) begin
      if (!stall_cmis) scnt++;
      else begin
        if (compq.size() == 0) check("unexpected_completion", 32'(datamem_readdata), 32'hFFFF_FFFF);
        else begin
          c = compq.pop_front();
          check(c.is_wr ? "wr_readdata" : "rd_data", 32'(datamem_readdata), 32'(c.data));
          check("stall_cycles", 32'(scnt), 32'(c.stalls));
        end
        scnt = 0;
      end
    end else begin
      scnt = 0;
    end
  end

  task automatic expect_mm(input logic we, input logic [15:0] a, input logic [15:0] wd);
    mmx_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    mmq.push_back(m);
  endtask

  task automatic expect_comp(input logic is_wr, input logic [15:0] d, input int s);
    comp_t c;
    c.is_wr = is_wr; c.data = d; c.stalls = s;
    compq.push_back(c);
  endtask

  task automatic do_access(input logic re, input logic we, input logic [15:0] a,
                           input logic [15:0] wd, input int l, input logic [15:0] r);
    int n;
    lat  = l;
    resp = r;
    @(posedge clk); #1;
    mem_re = re; modified_mem_we = we; datamem_add = a; datamem_writedata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stall_cmis && n < 100);
    if (!stall_cmis) check("access_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    mem_re = 1'b0; modified_mem_we = 1'b0;
  endtask

  task automatic idle_check(input string name);
    check({name, "_stall"}, 32'(stall_cmis), 32'd1);
    check({name, "_mm_req"}, 32'(mm_req), 32'd0);
    check({name, "_readdata"}, 32'(datamem_readdata), 32'd0);
    check({name, "_mm_addr"}, 32'({mm_we, mm_addr, mm_wdata}), 32'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(negedge clk); idle_check("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); idle_check("idle");

    // Cold read miss, then zero-cycle hit
    expect_mm(1'b0, 16'h0123, 16'h0); expect_comp(1'b0, 16'hBEEF, 4);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0, 3, 16'hBEEF);
    expect_comp(1'b0, 16'hBEEF, 0);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0, 3, 16'h0);

    // Conflict miss replaces the line; original address then misses again
    expect_mm(1'b0, 16'h0A23, 16'h0); expect_comp(1'b0, 16'h5555, 3);
    do_access(1'b1, 1'b0, 16'h0A23, 16'h0, 2, 16'h5555);
    expect_mm(1'b0, 16'h0123, 16'h0); expect_comp(1'b0, 16'hBEEF, 2);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0, 1, 16'hBEEF);

    // Write hit updates the line
    expect_mm(1'b1, 16'h0123, 16'h1234); expect_comp(1'b1, 16'h0, 3);
    do_access(1'b0, 1'b1, 16'h0123, 16'h1234, 2, 16'h0);
    expect_comp(1'b0, 16'h1234, 0);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0, 1, 16'h0);

    // Write miss does not allocate
    expect_mm(1'b1, 16'h0456, 16'h7777); expect_comp(1'b1, 16'h0, 2);
    do_access(1'b0, 1'b1, 16'h0456, 16'h7777, 1, 16'h0);
    expect_mm(1'b0, 16'h0456, 16'h0); expect_comp(1'b0, 16'h7777, 2);
    do_access(1'b1, 1'b0, 16'h0456, 16'h0, 1, 16'h7777);

    // Read + write together is a write
    expect_mm(1'b1, 16'h0123, 16'hAAAA); expect_comp(1'b1, 16'h0, 2);
    do_access(1'b1, 1'b1, 16'h0123, 16'hAAAA, 1, 16'h0);

    // Stray ack in IDLE is ignored
    @(posedge clk); #1; stray_seq++;
    @(negedge clk);
    @(negedge clk); idle_check("stray_ack");
    expect_comp(1'b0, 16'hAAAA, 0);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0, 1, 16'h0);

    // Reset during RMISS abandons the fill
    expect_mm(1'b0, 16'h0777, 16'h0);
    lat = 20; resp = 16'h1111;
    @(posedge clk); #1; mem_re = 1'b1; datamem_add = 16'h0777;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; mem_re = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); idle_check("rst_in_rmiss");
    @(posedge clk); #1; rst = 1'b0;
    expect_mm(1'b0, 16'h0777, 16'h0); expect_comp(1'b0, 16'h0F0F, 3);
    do_access(1'b1, 1'b0, 16'h0777, 16'h0, 2, 16'h0F0F);
    expect_comp(1'b0, 16'h0F0F, 0);
    do_access(1'b1, 1'b0, 16'h0777, 16'h0, 1, 16'h0);

    repeat (3) @(posedge clk);
    check("mmq_drained", 32'(mmq.size()), 32'd0);
    check("compq_drained", 32'(compq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter numbits, default 16: data and address width.
REQ-002 SHALL have parameter idx_bits, default 4: index width; the cache has 2^idx_bits lines of one word each.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port datamem_add  in  numbits: word address from the MEM stage.
REQ-006 SHALL have port datamem_writedata  in  numbits: store data from the MEM stage.
REQ-007 SHALL have port modified_mem_we  in  1: store request, already address-decoded.
REQ-008 SHALL have port mem_re  in  1: load request.
REQ-009 SHALL have port datamem_readdata  out  numbits: load data to forwarding muxes and WB.
REQ-010 SHALL have port stall_cmis  out  1: pipeline enable; 1 = run, 0 = freeze.
REQ-011 SHALL have port mm_req  out  1: main-memory request.
REQ-012 SHALL have port mm_we  out  1: main-memory write (1) or read (0).
REQ-013 SHALL have port mm_addr  out  numbits: main-memory word address.
REQ-014 SHALL have port mm_wdata  out  numbits: main-memory write data.
REQ-015 SHALL have port mm_rdata  in  numbits: main-memory read data, valid while mm_ack = 1.
REQ-016 SHALL have port mm_ack  in  1: one-cycle completion strobe from main memory.

Function
REQ-017 SHALL be direct-mapped: index = datamem_add[idx_bits-1:0], tag = datamem_add[numbits-1:idx_bits]; each line holds a valid bit, a tag and a data word.
REQ-018 SHALL use a write-through, no-write-allocate policy.
REQ-019 SHALL implement an FSM with states IDLE, RMISS, WTHRU and DONE.
REQ-020 SHALL treat access = mem_re | modified_mem_we; when both are set, the cycle SHALL be handled as a write.
REQ-021 SHALL define hit = valid[index] & (tag[index] == tag), combinational.
REQ-022 In IDLE with a read hit, SHALL drive datamem_readdata = line data and stall_cmis = 1 in the same cycle (zero-cycle hit); state SHALL remain IDLE.
REQ-023 In IDLE with a read miss, SHALL drive stall_cmis = 0 and move to RMISS.
REQ-024 In IDLE with a write, SHALL drive stall_cmis = 0, latch address and data, and move to WTHRU.
REQ-025 In IDLE with no access, SHALL drive stall_cmis = 1 and datamem_readdata = 0.
REQ-026 In RMISS, SHALL drive mm_req = 1, mm_we = 0, mm_addr = latched address and stall_cmis = 0.
REQ-027 In RMISS, on mm_ack, SHALL write mm_rdata, the tag and valid = 1 into the line, capture mm_rdata in a data register, and move to DONE.
REQ-028 In WTHRU, SHALL drive mm_req = 1, mm_we = 1, mm_addr and mm_wdata = latched values, and stall_cmis = 0.
REQ-029 In WTHRU, on mm_ack, SHALL update the line data only if the line hits (tag match and valid), then move to DONE.
REQ-030 In DONE, SHALL drive stall_cmis = 1 for exactly one cycle and start no new transaction; datamem_readdata SHALL equal the captured fill data after a read and 0 after a write. Next state SHALL be IDLE.
REQ-031 Outside RMISS and WTHRU, mm_req SHALL be 0, and mm_addr, mm_wdata and mm_we SHALL be 0.
REQ-032 SHALL ignore mm_ack outside RMISS and WTHRU; SHALL keep mm_req asserted without limit while waiting for mm_ack.
REQ-033 SHALL derive stall_cmis, datamem_readdata and the mm_* outputs combinationally from the state, the registered values and the inputs; the registered cache array SHALL read combinationally.
REQ-034 Miss penalty SHALL be 1 (detect) + N (cycles until mm_ack) + 1 (DONE) cycles with stall_cmis = 0 for 1 + N of them.

Reset
REQ-035 On rst = 1 at a clock edge, SHALL set state to IDLE, clear all valid bits, and clear the latched address, write data and fill data to 0; tags and line data need not be cleared.
REQ-036 rst asserted in RMISS or WTHRU SHALL abandon the transaction; mm_req SHALL be 0 from the cycle after the reset edge, and no line SHALL be written.
REQ-037 While rst = 1, all outputs SHALL take the IDLE/no-access values once the reset edge has occurred: stall_cmis = 1, mm_req = 0, datamem_readdata = 0.

Verification
REQ-038 Cold read: reset, then read addr 0x0123 with mm_ack after 3 cycles and mm_rdata = 0xBEEF -> stall_cmis = 0 for 4 cycles; DONE drives 0xBEEF with stall_cmis = 1; a re-read of 0x0123 hits with zero stall.
REQ-039 Conflict: after filling 0x0123, read 0x0A23 (same index, different tag) -> miss, mm_addr = 0x0A23, and the line is replaced.
REQ-040 Write hit: line 0x0123 valid, write 0x1234 -> mm_we = 1, mm_wdata = 0x1234; a later read of 0x0123 returns 0x1234 with no mm_req.
REQ-041 Write miss: write 0x0456 to an invalid line -> memory written, line stays invalid, and the next read of 0x0456 misses.
REQ-042 Simultaneous mem_re and modified_mem_we -> treated as a write (mm_we = 1); a stray mm_ack in IDLE causes no state change.
REQ-043 rst pulsed while in RMISS -> IDLE next cycle, mm_req = 0, and a read of the same address misses again.
